sprite_rom_arbiter: RTL and testbench



---
 rtl/sprite_rom_arbiter.sv | 153 +++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Arbitrates N_REQ draw units onto one sprite ROM, with burst lock and tagged responses.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority in place of round-robin.
module sprite_rom_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned MAX_BURST = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_rgb,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rgb
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(N_REQ - 1);

  typedef enum logic [0:0] {StFree, StOwned} lock_state_e;

  lock_state_e       state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rgb_q, rsp_rgb_d;
  // tag_q[0] is aligned with rom_addr_q; rom_rgb is expected to match tag_q[ROM_LAT-1]
  logic [N_REQ-1:0]  tag_q [ROM_LAT];

  logic [N_REQ-1:0]  gnt_raw;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  owner_oh;
  logic [PTR_W-1:0]  start_idx;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  win_idx;
  logic              win_vld;
  logic              hold;
  logic              at_max;
  logic              others;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]  rr_q, rr_d;
`endif

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned    k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_raw   = '0;
    win_idx   = '0;
    win_vld   = 1'b0;
    cand      = '0;
    elig      = req;
    owner_oh  = N_REQ'(1) << owner_q;
    hold      = (state_q == StOwned) && req[owner_q] && lock[owner_q];
    at_max    = (cnt_q == CntMax);
    others    = |(req & ~owner_oh);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    start_idx = '0;
`else
    start_idx = rr_q;
    rr_d      = rr_q;
`endif

    if (hold && !(at_max && others)) begin
      // Burst continues; a full burst with nobody waiting just restarts the count
      win_vld = 1'b1;
      win_idx = owner_q;
      cnt_d   = at_max ? CntOne : cnt_q + CntOne;
    end else begin
      if (hold) elig = req & ~owner_oh;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = wrap_add(start_idx, k);
        if (!win_vld && elig[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
      state_d = StFree;
      cnt_d   = '0;
      if (win_vld) begin
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        rr_d = (win_idx == LastIdx) ? '0 : win_idx + PTR_W'(1);
`endif
        if (lock[win_idx]) begin
          state_d = StOwned;
          owner_d = win_idx;
          cnt_d   = CntOne;
        end
      end
    end

    if (win_vld) gnt_raw[win_idx] = 1'b1;
  end

  always_comb begin
    gnt         = rst ? '0 : gnt_raw;
    rom_addr_d  = rom_addr_q;
    if (win_vld && !rst) rom_addr_d = addr[win_idx*ADDR_W +: ADDR_W];
    rsp_valid_d = tag_q[ROM_LAT-1];
    rsp_rgb_d   = (|tag_q[ROM_LAT-1]) ? rom_rgb : rsp_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFree;
      owner_q     <= '0;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rgb_q   <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rgb_q   <= rsp_rgb_d;
      tag_q[0]    <= gnt;
      for (int unsigned k = 1; k < ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rgb   = rsp_rgb_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: vector table plus burst, lock-release and reset sequences.
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [23:0] addr;
  logic [1:0]  gnt;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [1:0]  rsp_valid;
  logic [11:0] rsp_rgb;

  int n_chk = 0;
  int n_err = 0;

  sprite_rom_arbiter #(
    .N_REQ    (2),
    .ADDR_W   (12),
    .DATA_W   (12),
    .ROM_LAT  (1),
    .MAX_BURST(48)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_rgb  (rom_rgb),
    .rsp_valid(rsp_valid),
    .rsp_rgb  (rsp_rgb)
  );

  // ROM data array behind the DUT's registered address
  assign rom_rgb = rom_addr ^ 12'hFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [1:0]  gnt;
    logic [11:0] rom;
    logic [1:0]  rv;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    next_cycle();
    rst  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b11;
    lock = '0;
    addr = '0;

    // Reset holds for 3 clocks; grant must stay low even with requests present
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", {10'd0, gnt}, 12'h000);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_gnt", {10'd0, gnt}, 12'h000);
      chk("idle_rv", {10'd0, rsp_valid}, 12'h000);
      chk("idle_rom_addr", rom_addr, 12'h000);
      next_cycle();
    end

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    //          req    a0      a1      gnt    rom     rv     rgb
    vec[0]  = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h000, 2'b00, 12'h000};
    vec[1]  = '{2'b11, 12'h010, 12'h020, 2'b01, 12'h000, 2'b00, 12'h000};
    vec[2]  = '{2'b11, 12'h011, 12'h021, 2'b10, 12'h010, 2'b00, 12'h000};
    vec[3]  = '{2'b11, 12'h012, 12'h022, 2'b01, 12'h021, 2'b01, 12'hFEF};
    vec[4]  = '{2'b11, 12'h013, 12'h023, 2'b10, 12'h012, 2'b10, 12'hFDE};
    vec[5]  = '{2'b11, 12'h014, 12'h024, 2'b01, 12'h023, 2'b01, 12'hFED};
    vec[6]  = '{2'b11, 12'h015, 12'h025, 2'b10, 12'h014, 2'b10, 12'hFDC};
    vec[7]  = '{2'b01, 12'h041, 12'h000, 2'b01, 12'h025, 2'b01, 12'hFEB};
    vec[8]  = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h041, 2'b10, 12'hFDA};
    vec[9]  = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h041, 2'b01, 12'hFBE};
    vec[10] = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h041, 2'b00, 12'h000};
    vec[11] = '{2'b10, 12'h000, 12'h7C3, 2'b10, 12'h041, 2'b00, 12'h000};
    vec[12] = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h7C3, 2'b00, 12'h000};
    vec[13] = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h7C3, 2'b10, 12'h83C};
    for (int i = 0; i < NV; i++) begin
      req  = vec[i].req;
      lock = '0;
      addr = {vec[i].a1, vec[i].a0};
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {10'd0, gnt}, {10'd0, vec[i].gnt});
      chk($sformatf("v%0d_rom_addr", i), rom_addr, vec[i].rom);
      chk($sformatf("v%0d_rv", i), {10'd0, rsp_valid}, {10'd0, vec[i].rv});
      if (vec[i].rv != 2'b00) chk($sformatf("v%0d_rgb", i), rsp_rgb, vec[i].rgb);
      next_cycle();
    end
`else
    // Fixed priority: requester 0 wins every cycle under contention
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = 2'b11;
      @(negedge clk);
      chk("fixed_gnt", {10'd0, gnt}, 12'h001);
      next_cycle();
    end
`endif

    // Locked burst with contention: 48 grants to 0, one forced grant to 1, back to 0
    do_reset();
    addr = {12'h200, 12'h100};
    for (int c = 0; c < 60; c++) begin
      req  = 2'b11;
      lock = 2'b01;
      @(negedge clk);
      chk($sformatf("burst_c%0d", c), {10'd0, gnt}, (c == 48) ? 12'h002 : 12'h001);
      next_cycle();
    end

    // Locked burst alone: no forced rotation, grant stays on 0
    do_reset();
    for (int c = 0; c < 60; c++) begin
      req  = 2'b01;
      lock = 2'b01;
      @(negedge clk);
      chk($sformatf("solo_c%0d", c), {10'd0, gnt}, 12'h001);
      next_cycle();
    end

    // Dropping lock releases ownership; arbitration resumes after the owner
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req  = 2'b11;
      lock = (c < 3) ? 2'b01 : 2'b00;
      @(negedge clk);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      chk($sformatf("release_c%0d", c), {10'd0, gnt}, (c == 3) ? 12'h002 : 12'h001);
`else
      chk($sformatf("release_c%0d", c), {10'd0, gnt}, 12'h001);
`endif
      next_cycle();
    end

    // Reset with a read in flight: its response must never appear, pointer returns to 0
    do_reset();
    req  = 2'b01;
    lock = '0;
    @(negedge clk);
    chk("inflight_gnt", {10'd0, gnt}, 12'h001);
    next_cycle();
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    chk("rst_pulse_gnt", {10'd0, gnt}, 12'h000);
    next_cycle();
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rv%0d", c), {10'd0, rsp_valid}, 12'h000);
      next_cycle();
    end
    req = 2'b11;
    @(negedge clk);
    chk("post_rst_ptr", {10'd0, gnt}, 12'h001);
    next_cycle();
    req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
